// File: rtl/rggen_host_arbiter_pkg.sv
// Shared types and constants for the multi-host register-bus arbiter.
package rggen_host_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;

    // Host-index width; never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/rggen_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1 (mod NUM_HOSTS).
module rggen_rr_arbiter
    import rggen_host_arbiter_pkg::*;
#(
    parameter int NUM_HOSTS = 2,
    parameter int IDX_W     = clog2(NUM_HOSTS)
)(
    input  logic [NUM_HOSTS-1:0] request,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_HOSTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_index
);

    int   idx;
    logic found;

    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_HOSTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_HOSTS;
            if (!found && request[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_index = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rggen_host_arbiter.sv
// Arbitrates NUM_HOSTS command ports onto one register-block port, one transaction at a time.
// Optional macro RGGEN_HOST_ARBITER_TIMEOUT_EN aborts a stalled transaction with SLVERR.
module rggen_host_arbiter
    import rggen_host_arbiter_pkg::*;
#(
    parameter int NUM_HOSTS      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_HOSTS-1:0]                      i_command_valid,
    input  logic [NUM_HOSTS-1:0]                      i_write,
    input  logic [NUM_HOSTS-1:0]                      i_read,
    input  logic [NUM_HOSTS-1:0][ADDRESS_WIDTH-1:0]   i_address,
    input  logic [NUM_HOSTS-1:0][DATA_WIDTH/8-1:0]    i_strobe,
    input  logic [NUM_HOSTS-1:0][DATA_WIDTH-1:0]      i_write_data,
    output logic [NUM_HOSTS-1:0]                      o_response_ready,
    output logic [DATA_WIDTH-1:0]                     o_read_data,
    output logic [1:0]                                o_status,
    output logic                                      o_command_valid,
    output logic                                      o_write,
    output logic                                      o_read,
    output logic [ADDRESS_WIDTH-1:0]                  o_address,
    output logic [DATA_WIDTH/8-1:0]                   o_strobe,
    output logic [DATA_WIDTH-1:0]                     o_write_data,
    input  logic                                      i_response_ready,
    input  logic [DATA_WIDTH-1:0]                     i_read_data,
    input  logic [1:0]                                i_status
);

    localparam int IDX_W  = clog2(NUM_HOSTS);
    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                   state_reg, state_next;
    logic [IDX_W-1:0]         last_grant_reg;
    logic [IDX_W-1:0]         grant_reg;
    logic [IDX_W-1:0]         arb_index;
    logic [NUM_HOSTS-1:0]     arb_grant;
    logic                     write_reg;
    logic                     read_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic [STRB_W-1:0]        strobe_reg;
    logic [DATA_WIDTH-1:0]    write_data_reg;
    logic                     any_request;
    logic                     busy;
    logic                     completion;
    logic                     timed_out;

    rggen_rr_arbiter #(
        .NUM_HOSTS (NUM_HOSTS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .request     (i_command_valid),
        .last_grant  (last_grant_reg),
        .grant       (arb_grant),
        .grant_index (arb_index)
    );

    assign any_request = |arb_grant;
    assign busy        = (state_reg == BUSY);

`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timer_reg;

    // Counts BUSY cycles without a response; saturation is reached exactly at the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (busy && (state_next == BUSY)) begin
            timer_reg <= timer_reg + 1'b1;
        end else begin
            timer_reg <= '0;
        end
    end

    assign timed_out = busy && (timer_reg == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A real response takes priority over a simultaneous timeout.
    always_comb begin
        state_next  = state_reg;
        completion  = 1'b0;
        o_read_data = '0;
        o_status    = OKAY;
        case (state_reg)
            IDLE: begin
                if (any_request) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (i_response_ready) begin
                    completion  = 1'b1;
                    o_read_data = i_read_data;
                    o_status    = i_status;
                    state_next  = IDLE;
                end else if (timed_out) begin
                    completion = 1'b1;
                    o_status   = SLVERR;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= IDX_W'(NUM_HOSTS - 1);
            grant_reg      <= '0;
            write_reg      <= 1'b0;
            read_reg       <= 1'b0;
            address_reg    <= '0;
            strobe_reg     <= '0;
            write_data_reg <= '0;
        end else begin
            if (!busy && any_request) begin
                grant_reg      <= arb_index;
                write_reg      <= i_write[arb_index];
                read_reg       <= i_read[arb_index];
                address_reg    <= i_address[arb_index];
                strobe_reg     <= i_strobe[arb_index];
                write_data_reg <= i_write_data[arb_index];
            end
            if (completion) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

    assign o_command_valid = busy;
    assign o_write         = busy & write_reg;
    assign o_read          = busy & read_reg;
    assign o_address       = busy ? address_reg    : '0;
    assign o_strobe        = busy ? strobe_reg     : '0;
    assign o_write_data    = busy ? write_data_reg : '0;

    for (genvar gi = 0; gi < NUM_HOSTS; gi++) begin : g_response
        assign o_response_ready[gi] = completion && (grant_reg == IDX_W'(gi));
    end

endmodule

// File: doc/rggen_host_arbiter.md
RGGEN_HOST_ARBITER -- requirements
Module: rggen_host_arbiter

Interface
- REQ-001: Parameter NUM_HOSTS, default 2, number of requesting hosts (legal range 2..8) SHALL be supported.
- REQ-002: Parameter DATA_WIDTH, default 32, is the command and response data width.
- REQ-003: Parameter ADDRESS_WIDTH, default 8, is the local byte-address width.
- REQ-004: Parameter TIMEOUT_CYCLES, default 255, is the abort threshold; it is used only when REQ-027 is enabled.
- REQ-005: Port clk, input, 1 bit, the single clock.
- REQ-006: Port rst, input, 1 bit. Reset is asynchronous and active-high, on a single clock.
- REQ-007: Port i_command_valid, input, [NUM_HOSTS], per-host request.
- REQ-008: Ports i_write and i_read, input, [NUM_HOSTS], per-host access type.
- REQ-009: Port i_address, input, [NUM_HOSTS][ADDRESS_WIDTH], per-host byte address.
- REQ-010: Ports i_strobe, input, [NUM_HOSTS][DATA_WIDTH/8], and i_write_data, input, [NUM_HOSTS][DATA_WIDTH].
- REQ-011: Port o_response_ready, output, [NUM_HOSTS], per-host completion pulse.
- REQ-012: Ports o_read_data, output, [DATA_WIDTH], and o_status, output, 2 bits; both are broadcast to all hosts.
- REQ-013: Ports o_command_valid, o_write, o_read (output, 1 bit each), o_address, o_strobe and o_write_data (output, matching widths) drive the register block's command side.
- REQ-014: Ports i_response_ready (input, 1 bit), i_read_data (input, [DATA_WIDTH]) and i_status (input, 2 bits) return the register block's response.

Function
- REQ-015: The FSM SHALL have two states: IDLE and BUSY.
- REQ-016: In IDLE with any i_command_valid set, the block SHALL choose one host round-robin, searching upward from last_grant+1 modulo NUM_HOSTS.
- REQ-017: On that choice the block SHALL latch the granted host's write, read, address, strobe and write_data, and SHALL enter BUSY on the next edge.
- REQ-018: In BUSY, o_command_valid SHALL be 1 and the command outputs SHALL equal the latched fields.
  - Grant latency is 1 cycle from request to o_command_valid.
- REQ-019: The granted host's input changes or a valid drop during BUSY SHALL NOT affect the latched command; there is no abort.
- REQ-020: In BUSY, when i_response_ready is 1, the block SHALL, in the same cycle:
  - pulse o_response_ready[grant] for 1 cycle;
  - pass i_read_data to o_read_data and i_status to o_status.
- REQ-021: On that edge the block SHALL set last_grant to grant and return to IDLE.
- REQ-022: When not in the completion cycle, o_response_ready SHALL be 0 and o_read_data and o_status SHALL be 0.
- REQ-023: Back-to-back transactions SHALL have exactly one IDLE bubble cycle between completion and the next o_command_valid.
- REQ-024: A request arriving while BUSY SHALL wait; it SHALL NOT be lost, provided the host holds i_command_valid.
- REQ-025: If all hosts request continuously, each host SHALL be granted once every NUM_HOSTS transactions.

Reset
- REQ-026: While rst is 1, at any time including mid-transaction, the block SHALL:
  - force state to IDLE;
  - set last_grant to NUM_HOSTS-1, so host 0 has first priority;
  - clear the latched fields and drive every output to 0.
  - Any in-flight transaction is dropped without a response.

Configuration
- REQ-027: Macro RGGEN_HOST_ARBITER_TIMEOUT_EN behaves as follows.
  - Defined: a counter runs in BUSY. If i_response_ready is absent for TIMEOUT_CYCLES cycles, the block SHALL pulse o_response_ready[grant], drive o_status=2'b10 and o_read_data=0, and return to IDLE.
  - If i_response_ready arrives in the same cycle as the timeout, the real response SHALL win.
  - Undefined: no counter logic exists, and BUSY waits indefinitely.

Structure
- REQ-028: Package rggen_host_arbiter_pkg SHALL hold:
  - the state enum (IDLE, BUSY);
  - status constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10;
  - the host-index width function clog2(NUM_HOSTS).
- REQ-029: Sub-module rggen_rr_arbiter SHALL provide the combinational round-robin pick: request vector plus last_grant in, one-hot grant and index out.

Verification
- REQ-030: Reset, then host 1 write addr 8'h04, data 32'hDEADBEEF, strobe 4'hF.
  - Required: o_command_valid rises 1 cycle later with those fields.
  - Required: completion with i_status=0 gives o_response_ready=2'b10 for 1 cycle.
- REQ-031: Hosts 0 and 1 request simultaneously from reset, responses 2 cycles after command.
  - Required: host 0 is served first, host 1 second, with one idle bubble between.
  - Required: under a third simultaneous request, host 0 is served again.
- REQ-032: Host 0 read of addr 8'h10 returning i_read_data=32'h12345678, i_status=2'b10.
  - Required: o_read_data=32'h12345678 and o_status=2'b10 only in the o_response_ready[0] cycle.
- REQ-033: Host 0 changes i_address to 8'hFC in the cycle after grant.
  - Required: o_address stays at the original value until completion.
- REQ-034: rst asserted for 1 cycle while BUSY.
  - Required: o_command_valid is 0 immediately (asynchronously) and no o_response_ready occurs.
  - Required: the next request from host 1 with host 0 idle is granted normally.
- REQ-035: With RGGEN_HOST_ARBITER_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, i_response_ready is never asserted.
  - Required: o_response_ready[grant] rises 4 cycles after o_command_valid, with o_status=2'b10.
